// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: synchronizes bclk/lrclk/d into clk, deserializes standard I2S
// framing into stereo PCM pairs, and reports word length and framing faults.
module i2s_rx_deserializer #(
  parameter int unsigned DATA_W       = 24,
  parameter int unsigned MAX_BITS     = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned BCLK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_d,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              pcm_valid,
  output logic [7:0]        bit_cnt,
  output logic              frame_err,
  output logic              sync_lost
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned TMO_W = $clog2(BCLK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, LEFT, RIGHT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, d_sync;
  logic                   bclk_q, lr_prev_q, en_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      sh_q, sh_d;
  logic [DATA_W-1:0]      left_word_q, left_word_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;

  // Registered word-close events feeding the output stage
  logic                   close_q, short_q, pair_q, ovf_q, tmo_hit_q;
  logic [CNT_W-1:0]       close_n_q;
  logic [DATA_W-1:0]      pair_l_q, pair_r_q;

  logic                   bclk_s, lr_s, d_s, bedge_c, trans_c, en_rise_c;
  logic                   close_c, pair_c, ovf_c, tmo_hit_c;
  logic [CNT_W-1:0]       n_c;
  logic [DATA_W-1:0]      word_c;
  logic [IDX_W-1:0]       bit_idx_c;

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lr_s      = lr_sync[SYNC_STAGES-1];
  assign d_s       = d_sync[SYNC_STAGES-1];
  assign bedge_c   = bclk_s & ~bclk_q;
  assign trans_c   = bedge_c & (lr_s != lr_prev_q);
  assign en_rise_c = enable & ~en_q;
  assign bit_idx_c = IDX_W'(CNT_W'(DATA_W - 1) - cnt_q);

  // Input synchronizers and bclk edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      d_sync    <= '0;
      bclk_q    <= 1'b0;
    end else begin
      bclk_sync[0] <= i2s_bclk;
      lr_sync[0]   <= i2s_lrclk;
      d_sync[0]    <= i2s_d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        bclk_sync[i] <= bclk_sync[i-1];
        lr_sync[i]   <= lr_sync[i-1];
        d_sync[i]    <= d_sync[i-1];
      end
      bclk_q <= bclk_s;
    end
  end

  // State, word assembly and watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      left_word_q <= '0;
      tmo_q       <= '0;
      lr_prev_q   <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      left_word_q <= left_word_d;
      tmo_q       <= tmo_d;
      en_q        <= enable;
      if (bedge_c) lr_prev_q <= lr_s;
    end
  end

  // Next-state, bit assembly and event decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    left_word_d = left_word_q;
    tmo_d       = tmo_q;
    close_c     = 1'b0;
    pair_c      = 1'b0;
    ovf_c       = 1'b0;
    tmo_hit_c   = 1'b0;
    n_c         = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    word_c      = sh_q;
    if (cnt_q < CNT_W'(DATA_W)) word_c[bit_idx_c] = d_s;

    // The transition bedge carries the old word's LSB; the new word starts empty
    if (bedge_c) begin
      if (trans_c) begin
        cnt_d = '0;
        sh_d  = '0;
      end else begin
        cnt_d = n_c;
        sh_d  = word_c;
      end
    end

    if (bedge_c || !(state_q == LEFT || state_q == RIGHT)) tmo_d = '0;
    else                                                    tmo_d = tmo_q + TMO_W'(1);

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = ALIGN;
        ALIGN: if (trans_c && !lr_s) state_d = LEFT;
        LEFT, RIGHT: begin
          if (trans_c) begin
            close_c = 1'b1;
            if (state_q == LEFT) begin
              left_word_d = word_c;
              state_d     = RIGHT;
            end else begin
              pair_c  = 1'b1;
              state_d = LEFT;
            end
          end else if (bedge_c && cnt_q == CNT_W'(MAX_BITS)) begin
            ovf_c   = 1'b1;
            state_d = ALIGN;
          end else if (!bedge_c && tmo_q == TMO_W'(BCLK_TIMEOUT - 1)) begin
            tmo_hit_c = 1'b1;
            state_d   = ALIGN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Event stage: one clk after the closing bedge
  always_ff @(posedge clk) begin
    if (reset) begin
      close_q   <= 1'b0;
      close_n_q <= '0;
      short_q   <= 1'b0;
      pair_q    <= 1'b0;
      pair_l_q  <= '0;
      pair_r_q  <= '0;
      ovf_q     <= 1'b0;
      tmo_hit_q <= 1'b0;
    end else begin
      close_q   <= close_c;
      close_n_q <= n_c;
      short_q   <= close_c && (n_c < CNT_W'(DATA_W));
      pair_q    <= pair_c;
      ovf_q     <= ovf_c;
      tmo_hit_q <= tmo_hit_c;
      if (pair_c) begin
        pair_l_q <= left_word_q;
        pair_r_q <= word_c;
      end
    end
  end

  // Output registers; data and bit_cnt hold while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      left_data  <= '0;
      right_data <= '0;
      pcm_valid  <= 1'b0;
      bit_cnt    <= '0;
      frame_err  <= 1'b0;
      sync_lost  <= 1'b0;
    end else begin
      pcm_valid <= pair_q & enable;
      sync_lost <= tmo_hit_q;
      if (pair_q && enable) begin
        left_data  <= pair_l_q;
        right_data <= pair_r_q;
      end
      if (close_q && enable) bit_cnt <= close_n_q;
      if (en_rise_c)                frame_err <= 1'b0;
      else if (short_q || ovf_q)    frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: drives I2S frames with random words and checks
// received pairs against a word-level model of left-justified capture.
module tb_i2s_rx_deserializer;

  logic        clk = 1'b0;
  logic        reset, enable, i2s_bclk, i2s_lrclk, i2s_d;
  logic [23:0] left_data, right_data;
  logic        pcm_valid, frame_err, sync_lost;
  logic [7:0]  bit_cnt;

  i2s_rx_deserializer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_d(i2s_d),
    .left_data(left_data), .right_data(right_data), .pcm_valid(pcm_valid),
    .bit_cnt(bit_cnt), .frame_err(frame_err), .sync_lost(sync_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          n;
  } pair_t;

  pair_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          pcm_cnt  = 0;
  int          sl_cnt   = 0;
  logic [23:0] last_l   = '0;
  logic [23:0] last_r   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 24-bit sample for a word of nbits slots, MSB-first from w[63]
  function automatic logic [23:0] exp_word(input logic [63:0] w, input int nbits);
    logic [23:0] top;
    logic [23:0] ones;
    top  = w[63:40];
    ones = '1;
    if (nbits < 24) top = top & ~(ones >> nbits);
    return top;
  endfunction

  // Scoreboard: every pcm_valid must match the oldest expected pair
  always @(negedge clk) begin
    pair_t e;
    if (sync_lost) sl_cnt++;
    if (pcm_valid) begin
      pcm_cnt++;
      chk("pcm_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("left_data", 64'(left_data), 64'(e.l));
        chk("right_data", 64'(right_data), 64'(e.r));
        chk("bit_cnt@pcm", 64'(bit_cnt), 64'(e.n > 255 ? 255 : e.n));
        last_l = e.l;
        last_r = e.r;
      end
    end
  end

  // One bclk period: lr/d change while bclk is low, sampled on the rise
  task automatic slot(input logic lr, input logic d);
    @(negedge clk);
    i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_d = d;
    repeat (3) @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One channel word; lrclk flips on the LSB slot to announce the next channel
  task automatic send_word(input logic [63:0] w, input int nbits, input logic ch, input int en_at);
    logic [63:0] v;
    v = w;
    for (int i = 0; i < nbits; i++) begin
      if (i == en_at) enable = 1'b1;
      slot((i == nbits - 1) ? ~ch : ch, v[63 - i]);
    end
  endtask

  task automatic send_frames(input int nframes, input int nbits, input int skip,
                             input logic [63:0] fl, input logic [63:0] fr, input bit rnd);
    logic [63:0] l, r;
    for (int f = 0; f < nframes; f++) begin
      l = rnd ? {$urandom, $urandom} : fl;
      r = rnd ? {$urandom, $urandom} : fr;
      if (f >= skip) exp_q.push_back('{exp_word(l, nbits), exp_word(r, nbits), nbits});
      send_word(l, nbits, 1'b0, -1);
      send_word(r, nbits, 1'b1, -1);
    end
  endtask

  task automatic drain();
    repeat (20) @(negedge clk);
    chk("all_pairs_received", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int          pcm0, sl0;
    logic [63:0] w;
    reset = 1'b1; enable = 1'b0;
    i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_d = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_left", 64'(left_data), 64'(0));
    chk("rst_right", 64'(right_data), 64'(0));
    chk("rst_bit_cnt", 64'(bit_cnt), 64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    chk("rst_pcm_valid", 64'(pcm_valid), 64'(0));
    chk("rst_sync_lost", 64'(sync_lost), 64'(0));
    reset = 1'b0; enable = 1'b1;
    repeat (4) @(negedge clk);

    // 64fs frames, fixed then random words
    send_frames(4, 32, 1, 64'h123456 << 40, 64'hABCDEF << 40, 1'b0);
    drain();
    chk("t1_left", 64'(left_data), 64'h123456);
    chk("t1_right", 64'(right_data), 64'hABCDEF);
    chk("t1_pcm_cnt", 64'(pcm_cnt), 64'(3));
    send_frames(4, 32, 0, '0, '0, 1'b1);
    drain();
    chk("t1_bit_cnt", 64'(bit_cnt), 64'(32));
    chk("t1_frame_err", 64'(frame_err), 64'(0));
    chk("t1_pcm_cnt2", 64'(pcm_cnt), 64'(7));

    // 16 bclk/ch: zero-padded LSBs and sticky frame error
    send_frames(1, 16, 0, 64'h8001 << 48, 64'h7FFF << 48, 1'b0);
    drain();
    chk("t2_left", 64'(left_data), 64'h800100);
    chk("t2_right", 64'(right_data), 64'h7FFF00);
    chk("t2_bit_cnt", 64'(bit_cnt), 64'(16));
    chk("t2_frame_err", 64'(frame_err), 64'(1));
    send_frames(2, 16, 0, '0, '0, 1'b1);
    send_frames(1, 32, 0, '0, '0, 1'b1);
    drain();
    chk("t2_err_sticky", 64'(frame_err), 64'(1));
    chk("t2_bit_cnt32", 64'(bit_cnt), 64'(32));

    // Disable, then re-enable in the middle of a right word
    enable = 1'b0;
    pcm0 = pcm_cnt;
    w = {$urandom, $urandom};
    send_word(w, 32, 1'b0, -1);
    chk("t3_hold_left", 64'(left_data), 64'(last_l));
    chk("t3_hold_right", 64'(right_data), 64'(last_r));
    chk("t3_hold_bit_cnt", 64'(bit_cnt), 64'(32));
    chk("t3_err_held", 64'(frame_err), 64'(1));
    w = {$urandom, $urandom};
    send_word(w, 32, 1'b1, 16);
    chk("t3_err_cleared", 64'(frame_err), 64'(0));
    chk("t3_no_partial", 64'(pcm_cnt), 64'(pcm0));
    send_frames(2, 32, 0, '0, '0, 1'b1);
    drain();
    chk("t3_pcm_cnt", 64'(pcm_cnt - pcm0), 64'(2));

    // bclk stalls mid left word
    pcm0 = pcm_cnt; sl0 = sl_cnt;
    for (int i = 0; i < 10; i++) slot(1'b0, 1'($urandom));
    i2s_bclk = 1'b0;
    repeat (1100) @(negedge clk);
    chk("t4_sync_lost", 64'(sl_cnt - sl0), 64'(1));
    chk("t4_no_pcm", 64'(pcm_cnt - pcm0), 64'(0));
    send_frames(3, 32, 1, '0, '0, 1'b1);
    drain();
    chk("t4_resume_pcm", 64'(pcm_cnt - pcm0), 64'(2));

    // 40 bclk/ch overflows on the 33rd bclk
    pcm0 = pcm_cnt;
    for (int i = 0; i < 32; i++) slot(1'b0, 1'($urandom));
    repeat (2) @(negedge clk);
    chk("t5_err_at_32", 64'(frame_err), 64'(0));
    slot(1'b0, 1'($urandom));
    repeat (2) @(negedge clk);
    chk("t5_err_at_33", 64'(frame_err), 64'(1));
    for (int i = 33; i < 40; i++) slot((i == 39) ? 1'b1 : 1'b0, 1'($urandom));
    send_word({$urandom, $urandom}, 40, 1'b1, -1);
    send_frames(1, 40, 1, '0, '0, 1'b1);
    chk("t5_no_pcm", 64'(pcm_cnt - pcm0), 64'(0));
    send_frames(2, 32, 0, '0, '0, 1'b1);
    drain();
    chk("t5_recover_pcm", 64'(pcm_cnt - pcm0), 64'(2));
    chk("t5_err_sticky", 64'(frame_err), 64'(1));

    // Reset mid left word
    for (int i = 0; i < 10; i++) slot(1'b0, 1'($urandom));
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("t6_left", 64'(left_data), 64'(0));
    chk("t6_right", 64'(right_data), 64'(0));
    chk("t6_bit_cnt", 64'(bit_cnt), 64'(0));
    chk("t6_frame_err", 64'(frame_err), 64'(0));
    chk("t6_pcm_valid", 64'(pcm_valid), 64'(0));
    pcm0 = pcm_cnt;
    send_frames(3, 32, 1, '0, '0, 1'b1);
    drain();
    chk("t6_pcm_cnt", 64'(pcm_cnt - pcm0), 64'(2));
    chk("t6_frame_err_end", 64'(frame_err), 64'(0));
    chk("t6_bit_cnt_end", 64'(bit_cnt), 64'(32));
    chk("total_sync_lost", 64'(sl_cnt), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
